// File: rtl/uart_pkg.sv
// Shared UART definitions: the transmit FSM states, the parity helper and
// the default bit period. The receiver is expected to import this package too.
package uart_pkg;

  // Frame phases in transmission order.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

  // 50 MHz / 115200 baud.
  localparam int UART_CLKS_PER_BIT_DEF = 434;

  // Widest word par_calc accepts; narrower words are zero-extended, which
  // leaves the XOR unchanged.
  localparam int UART_PAR_W = 16;

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  function automatic logic par_calc(input logic [UART_PAR_W-1:0] data,
                                    input logic                  odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each period. A synchronous clear holds it at 0 so every period starts
// cleanly when the framer leaves idle.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic bit_end
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_end = (cnt_q == CW'(CLKS_PER_BIT - 1));

  // Wrap at the end of each period so the next state starts at 0.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || bit_end) cnt_d = '0;
  end

  // Counter register, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: accepts a word over valid/ready and serialises
// start, DATA_W data bits, optional parity and 1-2 stop bits onto tx_serial.
// A new word is accepted on the last stop cycle, so back-to-back frames leave
// no idle gap between them.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1,
  parameter int MSB_FIRST    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              tx_serial,
  output logic              tx_busy,
  output logic              frame_done
);

  localparam int BW = $clog2(DATA_W + 1);

  uart_tx_state_t    state_q;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [BW-1:0]     bit_idx_q;
  logic              par_q;
  logic              ser_q;

  logic bit_end;
  logic last_stop;
  logic stop_end;
  logic hs;

  // The counter idles cleared, so the start bit always gets a full period.
  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .clr     (state_q == IDLE),
    .bit_end (bit_end)
  );

  assign last_stop  = (bit_idx_q == BW'(STOP_BITS - 1));
  assign stop_end   = (state_q == STOP) && last_stop && bit_end;
  assign tx_ready   = (state_q == IDLE) || stop_end;
  assign hs         = tx_valid && tx_ready;
  assign tx_busy    = (state_q != IDLE);
  assign frame_done = stop_end;
  assign tx_serial  = ser_q;

  // Next shifter value: the bit just sent moves out, the next one moves to
  // the output end (bit 0 for LSB-first, bit DATA_W-1 for MSB-first).
  always_comb begin
    sh_d = {1'b0, sh_q[DATA_W-1:1]};
    if (MSB_FIRST != 0) sh_d = {sh_q[DATA_W-2:0], 1'b0};
  end

  // Frame FSM; the line level is registered and only changes on bit edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      sh_q      <= '0;
      bit_idx_q <= '0;
      par_q     <= 1'b0;
      ser_q     <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          ser_q <= 1'b1;
          if (hs) begin
            state_q   <= START;
            ser_q     <= 1'b0;
            sh_q      <= tx_data;
            par_q     <= par_calc(UART_PAR_W'(tx_data), PARITY_ODD != 0);
            bit_idx_q <= '0;
          end
        end
        START: begin
          if (bit_end) begin
            state_q   <= DATA;
            ser_q     <= (MSB_FIRST != 0) ? sh_q[DATA_W-1] : sh_q[0];
            bit_idx_q <= '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx_q == BW'(DATA_W - 1)) begin
              bit_idx_q <= '0;
              if (PARITY_EN != 0) begin
                state_q <= PARITY;
                ser_q   <= par_q;
              end else begin
                state_q <= STOP;
                ser_q   <= 1'b1;
              end
            end else begin
              sh_q      <= sh_d;
              ser_q     <= (MSB_FIRST != 0) ? sh_d[DATA_W-1] : sh_d[0];
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state_q   <= STOP;
            ser_q     <= 1'b1;
            bit_idx_q <= '0;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (last_stop) begin
              bit_idx_q <= '0;
              if (hs) begin
                // Gapless follow-on frame: start bit begins next cycle.
                state_q <= START;
                ser_q   <= 1'b0;
                sh_q    <= tx_data;
                par_q   <= par_calc(UART_PAR_W'(tx_data), PARITY_ODD != 0);
              end else begin
                state_q <= IDLE;
                ser_q   <= 1'b1;
              end
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          ser_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: four instances with different frame formats,
// every cycle of each frame compared against a bit-position model of the
// UART frame.
module tb_uart_tx_framer;

  localparam int C = 4;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       vld  [N];
  logic [8:0] dat  [N];
  logic       ser  [N];
  logic       rdy  [N];
  logic       busy [N];
  logic       done [N];

  int checks = 0;
  int errors = 0;

  // 0: 8N1 LSB-first   1: 8E1   2: 8O1   3: 7N2 MSB-first
  uart_tx_framer #(.DATA_W(8), .CLKS_PER_BIT(C)) u0 (
    .clk(clk), .reset(reset), .tx_valid(vld[0]), .tx_data(dat[0][7:0]),
    .tx_ready(rdy[0]), .tx_serial(ser[0]), .tx_busy(busy[0]), .frame_done(done[0]));
  uart_tx_framer #(.DATA_W(8), .CLKS_PER_BIT(C), .PARITY_EN(1)) u1 (
    .clk(clk), .reset(reset), .tx_valid(vld[1]), .tx_data(dat[1][7:0]),
    .tx_ready(rdy[1]), .tx_serial(ser[1]), .tx_busy(busy[1]), .frame_done(done[1]));
  uart_tx_framer #(.DATA_W(8), .CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(1)) u2 (
    .clk(clk), .reset(reset), .tx_valid(vld[2]), .tx_data(dat[2][7:0]),
    .tx_ready(rdy[2]), .tx_serial(ser[2]), .tx_busy(busy[2]), .frame_done(done[2]));
  uart_tx_framer #(.DATA_W(7), .CLKS_PER_BIT(C), .STOP_BITS(2), .MSB_FIRST(1)) u3 (
    .clk(clk), .reset(reset), .tx_valid(vld[3]), .tx_data(dat[3][6:0]),
    .tx_ready(rdy[3]), .tx_serial(ser[3]), .tx_busy(busy[3]), .frame_done(done[3]));

  function automatic int p_w(int i);   return (i == 3) ? 7 : 8;               endfunction
  function automatic int p_pe(int i);  return (i == 1 || i == 2) ? 1 : 0;     endfunction
  function automatic int p_po(int i);  return (i == 2) ? 1 : 0;               endfunction
  function automatic int p_sb(int i);  return (i == 3) ? 2 : 1;               endfunction
  function automatic int p_msb(int i); return (i == 3) ? 1 : 0;               endfunction
  function automatic int frame_len(int i);
    return (1 + p_w(i) + p_pe(i) + p_sb(i)) * C;
  endfunction

  // Line level for bit position p of a frame carrying d.
  function automatic logic exp_bit(int i, logic [8:0] d, int p);
    int w;
    int ones;
    w = p_w(i);
    if (p == 0) return 1'b0;
    if (p <= w) return (p_msb(i) != 0) ? d[w - p] : d[p - 1];
    if (p == w + 1 && p_pe(i) != 0) begin
      ones = 0;
      for (int j = 0; j < w; j++) ones += int'(d[j]);
      return ((ones % 2) == 1) ^ (p_po(i) != 0);
    end
    return 1'b1;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(int i, string tag);
    chk($sformatf("%s_ser%0d", tag, i),  32'(ser[i]),  32'd1);
    chk($sformatf("%s_rdy%0d", tag, i),  32'(rdy[i]),  32'd1);
    chk($sformatf("%s_busy%0d", tag, i), 32'(busy[i]), 32'd0);
    chk($sformatf("%s_done%0d", tag, i), 32'(done[i]), 32'd0);
  endtask

  // Present d and return just after the accepting edge.
  task automatic offer(int i, logic [8:0] d);
    int n;
    @(negedge clk);
    vld[i] = 1'b1;
    dat[i] = d;
    n = 0;
    while (!rdy[i] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("offer_ready%0d", i), 32'(rdy[i]), 32'd1);
    @(posedge clk);
  endtask

  // Check every cycle of a frame that started at the last edge. With keep set
  // the next word nd is held valid so it is taken on the last stop cycle.
  task automatic run_frame(int i, logic [8:0] d, logic keep, logic [8:0] nd);
    int L;
    L = frame_len(i);
    for (int k = 0; k < L; k++) begin
      @(negedge clk);
      if (k == 0) begin
        if (keep) dat[i] = nd;
        else begin
          vld[i] = 1'b0;
          dat[i] = ~d;
        end
      end
      if (!keep && k == L / 2) dat[i] = 9'($urandom);
      chk($sformatf("ser%0d_k%0d", i, k),  32'(ser[i]),  32'(exp_bit(i, d, k / C)));
      chk($sformatf("busy%0d_k%0d", i, k), 32'(busy[i]), 32'd1);
      chk($sformatf("done%0d_k%0d", i, k), 32'(done[i]), 32'(k == L - 1));
      chk($sformatf("rdy%0d_k%0d", i, k),  32'(rdy[i]),  32'(k == L - 1));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] d;
    int         i;
    for (int j = 0; j < N; j++) begin
      vld[j] = 1'b0;
      dat[j] = '0;
    end

    // Reset state, then 100 quiet cycles.
    repeat (3) @(negedge clk);
    for (int j = 0; j < N; j++) check_idle(j, "in_reset");
    reset = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      for (int j = 0; j < N; j++) check_idle(j, "quiet");
    end

    // 8N1, 0xA5.
    offer(0, 9'h0A5);
    run_frame(0, 9'h0A5, 1'b0, 9'h0);
    @(negedge clk); check_idle(0, "after_a5");

    // Parity: even 0x07, even 0x00, odd 0x07.
    offer(1, 9'h007);
    run_frame(1, 9'h007, 1'b0, 9'h0);
    @(negedge clk); check_idle(1, "after_e07");
    offer(1, 9'h000);
    run_frame(1, 9'h000, 1'b0, 9'h0);
    offer(2, 9'h007);
    run_frame(2, 9'h007, 1'b0, 9'h0);
    @(negedge clk); check_idle(2, "after_o07");

    // Back-to-back with valid held: 0x55 then 0x0F, no gap.
    offer(0, 9'h055);
    run_frame(0, 9'h055, 1'b1, 9'h00F);
    run_frame(0, 9'h00F, 1'b0, 9'h0);
    @(negedge clk); check_idle(0, "after_b2b");

    // Reset during data bit 3 of 0xFF, then a clean 0x3C frame.
    offer(0, 9'h0FF);
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      if (k == 0) vld[0] = 1'b0;
      chk($sformatf("pre_abort_ser_k%0d", k), 32'(ser[0]), 32'(exp_bit(0, 9'h0FF, k / C)));
    end
    reset = 1'b0;
    #1;
    check_idle(0, "abort");
    @(negedge clk);
    reset = 1'b1;
    offer(0, 9'h03C);
    run_frame(0, 9'h03C, 1'b0, 9'h0);
    @(negedge clk); check_idle(0, "after_3c");

    // 7N2 MSB-first, 0x41.
    offer(3, 9'h041);
    run_frame(3, 9'h041, 1'b0, 9'h0);
    @(negedge clk); check_idle(3, "after_41");

    // Random words on random instances.
    for (int r = 0; r < 8; r++) begin
      i = int'($urandom_range(0, N - 1));
      d = 9'($urandom) & 9'((1 << p_w(i)) - 1);
      offer(i, d);
      run_frame(i, d, 1'b0, 9'h0);
      @(negedge clk); check_idle(i, "after_rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_framer.md
Name: uart_tx_framer

Overview:
Parametrised UART transmit path that replaces the fixed 8-bit parallel-in/serial-out shifter and its external load/shift control. It accepts a word through a valid/ready handshake and generates the complete serial frame itself: start bit, DATA_W data bits, optional parity, and 1 or 2 stop bits. It has an internal bit-period counter and drives the TX pin directly. It sits between the host-side transmit buffer and the pad.

Parameters:
DATA_W, 8, data bits per frame (legal 5..9)
CLKS_PER_BIT, 434, clk cycles per bit period (>=2; 434 = 50 MHz / 115200)
PARITY_EN, 0, 1 = parity bit inserted after data
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0)
STOP_BITS, 1, number of stop bits (1 or 2)
MSB_FIRST, 0, 0 = LSB transmitted first, 1 = MSB first

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
tx_valid  in  1  host offers a word
tx_data  in  DATA_W  word to send; sampled only on handshake
tx_ready  out  1  block can accept a word this cycle
tx_serial  out  1  serial line, idle high
tx_busy  out  1  frame in progress (START..STOP)
frame_done  out  1  one-cycle pulse on the final clk of the last stop bit

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=IDLE, tx_serial=1, tx_ready=1, tx_busy=0, frame_done=0, shift register and counters=0. Reset mid-frame aborts immediately; line goes high in the same instant, no partial frame resumes.
- Handshake: transfer occurs on a clk edge with tx_valid && tx_ready. tx_data is latched into the shift register; tx_data changes after the handshake have no effect. Parity is computed from the latched word at the handshake: even = XOR of data bits; odd = inverted XOR.
- tx_ready = (state==IDLE) || (state==STOP && last stop bit && bit counter == CLKS_PER_BIT-1). This allows gapless back-to-back frames.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on handshake. The start bit (tx_serial=0) begins on the next cycle.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA: emits bit[0] (LSB-first) or bit[DATA_W-1] (MSB-first). Shifts once per bit period. After DATA_W periods -> PARITY if PARITY_EN, else STOP.
  - PARITY: one period -> STOP.
  - STOP: tx_serial=1 for STOP_BITS periods. At the end, -> START if a handshake occurred in that cycle, else -> IDLE.
- tx_serial is registered and changes only on bit boundaries. tx_busy=1 in every state except IDLE.
- Bit-period counter runs 0..CLKS_PER_BIT-1 and is reset to 0 on every state entry. Width = clog2(CLKS_PER_BIT). Bit index counter width = clog2(DATA_W+1).
- Frame length = (1 + DATA_W + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles, measured from the first start-bit cycle.
- frame_done pulses exactly once per frame, coincident with the final cycle of the last stop bit.
- tx_valid held high while busy has no effect until tx_ready asserts.

Decomposition:
- Shared package uart_pkg:
  - state enum uart_tx_state_t {IDLE, START, DATA, PARITY, STOP}
  - parity function par_calc(data, odd)
  - localparam default CLKS_PER_BIT
  - The future receiver reuses this package.
- One sub-module, uart_baud_cnt: a CLKS_PER_BIT counter with sync clear input and bit_end output, instantiated once. The FSM, shifter and parity logic stay in uart_tx_framer.

Test Plan:
1. Reset asserted, then released with no tx_valid -> tx_serial=1, tx_ready=1, tx_busy=0, frame_done=0 for 100 cycles.
2. CLKS_PER_BIT=4, DATA_W=8, defaults; send 0xA5 -> line sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. Frame is 40 cycles, frame_done on cycle 40, tx_ready high on cycle 40.
3. PARITY_EN=1: 0x07 even -> parity bit 1; 0x07 with PARITY_ODD=1 -> 0; 0x00 even -> 0. Frame is 44 cycles.
4. tx_valid held with 0x55 then 0x0F -> second start bit begins the cycle after the first frame's last stop cycle (no idle gap). Exactly two frame_done pulses, 40 cycles apart.
5. Reset pulsed during data bit 3 of 0xFF -> tx_serial=1 immediately, tx_busy=0. After release, 0x3C is sent as a clean 40-cycle frame.
6. MSB_FIRST=1, DATA_W=7, STOP_BITS=2, send 0x41 -> 0, then 1,0,0,0,0,0,1, then 1,1. Frame is 40 cycles; tx_data toggled mid-frame does not alter the bits.
